// File: rtl/asp_mmio_csr_responder_if.sv
// 64-bit Avalon-MM MMIO bundle between the platform shim and the AFU CSR responder.
interface asp_mmio_csr_responder_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [63:0]           writedata;
    logic [7:0]            byteenable;
    logic                  waitrequest;
    logic [63:0]           readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/asp_mmio_csr_responder.sv
// MMIO CSR responder: DFH/GUID header, scratch, timestamp and status words,
// fixed-latency in-order read returns throttled by an outstanding-read credit.
module asp_mmio_csr_responder #(
    parameter int          ADDR_WIDTH      = 16,
    parameter logic [63:0] DFH_VALUE       = 64'h0,
    parameter logic [63:0] GUID_L          = 64'h0,
    parameter logic [63:0] GUID_H          = 64'h0,
    parameter int          NUM_SCRATCH     = 4,
    parameter int          READ_LATENCY    = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                     pClk,
    input  logic                     pClk_reset,
    asp_mmio_csr_responder_if.slave  mmio
);
    localparam int SCR_LO = 3;
    localparam logic [ADDR_WIDTH-1:0] A_DFH = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_GL  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_GH  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_TS  = ADDR_WIDTH'(16'h10);
    localparam logic [ADDR_WIDTH-1:0] A_ST  = ADDR_WIDTH'(16'h11);

    logic [63:0] scratch_q [NUM_SCRATCH];
    logic [63:0] scratch_d [NUM_SCRATCH];
    logic [63:0] ts_q, ts_d;
    logic [1:0]  st_q, st_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [63:0] dat_q [READ_LATENCY];
    logic [63:0] dat_d [READ_LATENCY];

    logic        rdv;
    logic        wait_o;
    logic        acc;
    logic        acc_rd;
    logic        acc_wr;
    logic        mapped;
    logic [63:0] rd_val;
    logic [3:0]  cnt_eff;

    // A response leaving this cycle already returns its credit.
    assign rdv     = vld_q[READ_LATENCY-1];
    assign cnt_eff = cnt_q - {3'b0, rdv};
    assign wait_o  = pClk_reset || (cnt_eff == 4'(MAX_OUTSTANDING));

    assign mmio.waitrequest   = wait_o;
    assign mmio.readdatavalid = rdv;
    assign mmio.readdata      = dat_q[READ_LATENCY-1];

    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (mmio.address)
            A_DFH:   rd_val = DFH_VALUE;
            A_GL:    rd_val = GUID_L;
            A_GH:    rd_val = GUID_H;
            A_TS:    rd_val = ts_q;
            A_ST:    rd_val = {52'h0, cnt_q, 6'h0, st_q};
            default: begin
                mapped = 1'b0;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (mmio.address == ADDR_WIDTH'(SCR_LO + i)) begin
                        mapped = 1'b1;
                        rd_val = scratch_q[i];
                    end
                end
            end
        endcase
    end

    always_comb begin
        acc    = (mmio.read || mmio.write) && !wait_o;
        acc_wr = acc && mmio.write;
        acc_rd = acc && mmio.read && !mmio.write;

        ts_d = ts_q + 64'd1;

        st_d = st_q;
        if (acc_wr && mmio.address == A_ST && mmio.byteenable[0]) begin
            st_d = st_q & ~mmio.writedata[1:0];
        end
        if (acc && mmio.read && mmio.write) begin
            st_d[0] = 1'b1;
        end
        if (acc && !mapped) begin
            st_d[1] = 1'b1;
        end

        scratch_d = scratch_q;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (acc_wr && mmio.address == ADDR_WIDTH'(SCR_LO + i)) begin
                for (int b = 0; b < 8; b++) begin
                    if (mmio.byteenable[b]) begin
                        scratch_d[i][8*b +: 8] = mmio.writedata[8*b +: 8];
                    end
                end
            end
        end

        cnt_d = cnt_q + {3'b0, acc_rd} - {3'b0, rdv};

        vld_d[0] = acc_rd;
        dat_d[0] = acc_rd ? rd_val : 64'h0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            ts_q  <= '0;
            st_q  <= '0;
            cnt_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            ts_q  <= ts_d;
            st_q  <= st_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end
endmodule

// File: tb/tb_asp_mmio_csr_responder.sv
// Directed bench for the MMIO CSR responder: register map table plus
// hand-written credit, error, timestamp and mid-reset sequences.
module tb_asp_mmio_csr_responder;
    localparam logic [63:0] DFH = 64'h1000_0000_0000_1234;
    localparam logic [63:0] GL  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] GH  = 64'h5555_6666_7777_8888;
    localparam int RL = 4;

    logic pClk;
    logic pClk_reset;
    int   checks;
    int   errors;

    asp_mmio_csr_responder_if #(.ADDR_WIDTH(16)) bus ();

    asp_mmio_csr_responder #(
        .ADDR_WIDTH(16), .DFH_VALUE(DFH), .GUID_L(GL), .GUID_H(GH),
        .NUM_SCRATCH(4), .READ_LATENCY(RL), .MAX_OUTSTANDING(2)
    ) dut (
        .pClk(pClk),
        .pClk_reset(pClk_reset),
        .mmio(bus)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        wr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
        int n;
        bus.address = a;
        bus.writedata = d;
        bus.byteenable = be;
        bus.write = 1'b1;
        n = 0;
        while (bus.waitrequest && n < 20) begin
            @(negedge pClk);
            n++;
        end
        if (n >= 20) chk("write_timeout", 64'(n), 64'(0));
        @(posedge pClk);
        @(negedge pClk);
        bus.write = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [63:0] d, output int lat);
        int n;
        bus.address = a;
        bus.read = 1'b1;
        n = 0;
        while (bus.waitrequest && n < 20) begin
            @(negedge pClk);
            n++;
        end
        if (n >= 20) chk("read_accept_timeout", 64'(n), 64'(0));
        @(posedge pClk);
        @(negedge pClk);
        bus.read = 1'b0;
        lat = 1;
        while (!bus.readdatavalid && lat < 20) begin
            @(negedge pClk);
            lat++;
        end
        if (lat >= 20) chk("read_resp_timeout", 64'(lat), 64'(RL));
        d = bus.readdata;
        @(negedge pClk);
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] d2;
        int lat;
        int n;
        int k;
        logic [63:0] q [$];
        logic [63:0] ts [$];
        logic [15:0] t3_addr [5];
        logic [63:0] t3_exp [5];
        logic [7:0]  exp_wr;
        logic [11:0] exp_rdv;

        checks = 0;
        errors = 0;
        pClk_reset = 1'b1;
        bus.address = '0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.writedata = '0;
        bus.byteenable = '0;

        vecs[0]  = '{"dfh",          16'h0,  1'b0, 64'h0, 8'h00, DFH};
        vecs[1]  = '{"guid_l",       16'h1,  1'b0, 64'h0, 8'h00, GL};
        vecs[2]  = '{"guid_h",       16'h2,  1'b0, 64'h0, 8'h00, GH};
        vecs[3]  = '{"status_rst",   16'h11, 1'b0, 64'h0, 8'h00, 64'h0};
        vecs[4]  = '{"scr3_full",    16'h3,  1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[5]  = '{"scr3_low",     16'h3,  1'b1, 64'h0, 8'h0F, 64'hDEAD_BEEF_0000_0000};
        vecs[6]  = '{"scr6_lanes",   16'h6,  1'b1, 64'h0123_4567_89AB_CDEF, 8'h81, 64'h0100_0000_0000_00EF};
        vecs[7]  = '{"ro_dfh",       16'h0,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, DFH};
        vecs[8]  = '{"unmapped7",    16'h7,  1'b1, 64'h1234, 8'hFF, 64'h0};
        vecs[9]  = '{"status_unmap", 16'h11, 1'b0, 64'h0, 8'h00, 64'h2};
        vecs[10] = '{"status_w1c",   16'h11, 1'b1, 64'h2, 8'h01, 64'h0};
        vecs[11] = '{"unmapped40",   16'h40, 1'b0, 64'h0, 8'h00, 64'h0};
        vecs[12] = '{"status_40",    16'h11, 1'b0, 64'h0, 8'h00, 64'h2};
        vecs[13] = '{"status_nobe0", 16'h11, 1'b1, 64'h3, 8'hFE, 64'h2};
        vecs[14] = '{"status_clr",   16'h11, 1'b1, 64'h2, 8'h01, 64'h0};

        // T1 reset
        for (int i = 0; i < 3; i++) begin
            @(negedge pClk);
            chk("rst_waitreq", 64'(bus.waitrequest), 64'(1));
            chk("rst_rdv", 64'(bus.readdatavalid), 64'(0));
        end
        chk("rst_rdata", bus.readdata, 64'h0);
        pClk_reset = 1'b0;
        #1;
        chk("rel_waitreq", 64'(bus.waitrequest), 64'(0));
        @(negedge pClk);
        do_read(16'h0, d, lat);
        chk("t1_dfh", d, DFH);
        chk("t1_latency", 64'(lat), 64'(RL));

        // register map table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            do_read(vecs[i].addr, d, lat);
            chk(vecs[i].name, d, vecs[i].exp);
        end

        // T3 credits: read held 8 cycles
        t3_addr = '{16'h0, 16'h1, 16'h2, 16'h0, 16'h1};
        t3_exp  = '{DFH, GL, GH, DFH, GL};
        exp_wr  = 8'hCC;
        exp_rdv = 12'h330;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge pClk);
            if (i < 8) begin
                bus.read = 1'b1;
                bus.address = t3_addr[k];
                chk($sformatf("t3_waitreq_c%0d", i), 64'(bus.waitrequest), 64'(exp_wr[i]));
                if (!bus.waitrequest && k < 4) begin
                    q.push_back(t3_exp[k]);
                    k++;
                end
            end else begin
                bus.read = 1'b0;
            end
            chk($sformatf("t3_rdv_c%0d", i), 64'(bus.readdatavalid), 64'(exp_rdv[i]));
            if (bus.readdatavalid && q.size() > 0) begin
                chk($sformatf("t3_order_c%0d", i), bus.readdata, q.pop_front());
            end
        end
        @(negedge pClk);
        do_read(16'h11, d, lat);
        chk("t3_status_idle", d, 64'h0);

        // T4 read&&write collision on word 4
        bus.address = 16'h4;
        bus.writedata = 64'h5555_AAAA_5555_AAAA;
        bus.byteenable = 8'hFF;
        bus.read = 1'b1;
        bus.write = 1'b1;
        @(posedge pClk);
        @(negedge pClk);
        bus.read = 1'b0;
        bus.write = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.readdatavalid) n++;
            @(negedge pClk);
        end
        chk("t4_no_rdv", 64'(n), 64'(0));
        do_read(16'h4, d, lat);
        chk("t4_write_lands", d, 64'h5555_AAAA_5555_AAAA);
        do_read(16'h11, d, lat);
        chk("t4_status_coll", d, 64'h1);
        do_write(16'h11, 64'h1, 8'h01);
        do_read(16'h11, d, lat);
        chk("t4_status_clr", d, 64'h0);

        // T5 timestamp: accepts 10 cycles apart
        for (int i = 0; i < 16; i++) begin
            @(negedge pClk);
            if (bus.readdatavalid) ts.push_back(bus.readdata);
            bus.address = 16'h10;
            bus.read = (i == 0 || i == 10);
        end
        bus.read = 1'b0;
        chk("t5_resp_count", 64'(ts.size()), 64'(2));
        if (ts.size() == 2) begin
            d = ts[0];
            d2 = ts[1];
            chk("t5_ts_delta", d2 - d, 64'd10);
        end
        @(negedge pClk);
        force dut.ts_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("t5_ts_wrap", dut.ts_d, 64'h0);
        release dut.ts_q;
        @(negedge pClk);

        // T6 reset one cycle after a read accept
        bus.address = 16'h0;
        bus.read = 1'b1;
        @(posedge pClk);
        @(negedge pClk);
        bus.read = 1'b0;
        pClk_reset = 1'b1;
        #1;
        chk("t6_waitreq", 64'(bus.waitrequest), 64'(1));
        @(negedge pClk);
        pClk_reset = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.readdatavalid) n++;
            @(negedge pClk);
        end
        chk("t6_no_rdv", 64'(n), 64'(0));
        do_read(16'h11, d, lat);
        chk("t6_status_out0", d, 64'h0);
        do_read(16'h3, d, lat);
        chk("t6_scratch_rst", d, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
